// File: rtl/disp_pkg.sv
// Shared constants for the character scroll display: active-low segment patterns
// (bit7 = DP) and the scroll mode encodings.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;

  typedef enum logic [1:0] {
    MODE_MAN   = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_LEFT) || (mode == MODE_RIGHT);
  endfunction

endpackage

// File: rtl/char_7seg_dec.sv
// Combinational character-code to 7-segment decoder with a forced-blank input.
module char_7seg_dec
  import disp_pkg::*;
#(
  parameter int CHAR_W = 2
) (
  input  logic [CHAR_W-1:0] i_code,
  input  logic              i_blank,
  output logic [7:0]        o_seg
);

  // code to segment lookup; codes above 3 have no glyph
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_code)
        CHAR_W'(0): o_seg = SEG_D;
        CHAR_W'(1): o_seg = SEG_E;
        CHAR_W'(2): o_seg = SEG_1;
        CHAR_W'(3): o_seg = SEG_0;
        default:    o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/char_scroll_display.sv
// Latches N_DIGITS character codes and rotates them across the 7-segment digits,
// either by a manual offset or by a timed left/right scroll with hold.
module char_scroll_display
  import disp_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CHAR_W   = 2,
  parameter int TICK_DIV = 50_000_000,
  localparam int OFF_W   = $clog2(N_DIGITS)
) (
  input  logic                       fr_CLK,
  input  logic                       fr_RST_N,
  input  logic [N_DIGITS*CHAR_W-1:0] fr_chars,
  input  logic                       fr_load,
  input  logic [1:0]                 fr_mode,
  input  logic [OFF_W-1:0]           fr_sel,
  output logic [N_DIGITS*8-1:0]      to_HEX,
  output logic [OFF_W-1:0]           to_offset,
  output logic                       to_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(N_DIGITS - 1);

  logic [N_DIGITS*CHAR_W-1:0] r_chars;
  logic                       r_valid;
  logic [PW-1:0]              r_presc;
  logic [PW-1:0]              w_presc_nxt;
  logic [OFF_W-1:0]           r_offset;
  logic [OFF_W-1:0]           w_offset_nxt;
  logic                       r_tick;
  logic                       w_step;
  logic [N_DIGITS*8-1:0]      r_hex;
  logic [N_DIGITS*8-1:0]      w_hex;

  // prescaler advance and per-mode offset update
  always_comb begin
    w_presc_nxt  = '0;
    w_step       = 1'b0;
    w_offset_nxt = r_offset;
    if (is_auto(fr_mode)) begin
      if (r_presc == PW'(TICK_DIV - 1)) begin
        w_presc_nxt = '0;
        w_step      = 1'b1;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else begin
      w_presc_nxt = '0;
    end
    case (mode_e'(fr_mode))
      MODE_MAN: begin
        if ({1'b0, fr_sel} < (OFF_W+1)'(N_DIGITS)) w_offset_nxt = fr_sel;
        else w_offset_nxt = r_offset;
      end
      MODE_LEFT: begin
        if (w_step) w_offset_nxt = (r_offset == LAST_OFF) ? '0 : r_offset + OFF_W'(1);
        else w_offset_nxt = r_offset;
      end
      MODE_RIGHT: begin
        if (w_step) w_offset_nxt = (r_offset == '0) ? LAST_OFF : r_offset - OFF_W'(1);
        else w_offset_nxt = r_offset;
      end
      default: w_offset_nxt = r_offset;
    endcase
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    logic [OFF_W:0]      w_sum;
    logic [OFF_W:0]      w_idx;
    logic [CHAR_W-1:0]   w_code;
    logic [7:0]          w_seg;

    // digit i shows char[(i - offset) mod N_DIGITS]; offset never exceeds N_DIGITS-1
    always_comb begin
      w_sum = (OFF_W+1)'(i + N_DIGITS) - {1'b0, r_offset};
      if (w_sum >= (OFF_W+1)'(N_DIGITS)) w_idx = w_sum - (OFF_W+1)'(N_DIGITS);
      else w_idx = w_sum;
      w_code = r_chars[int'(w_idx)*CHAR_W +: CHAR_W];
    end

    char_7seg_dec #(.CHAR_W(CHAR_W)) u_dec (
      .i_code  (w_code),
      .i_blank (!r_valid),
      .o_seg   (w_seg)
    );

    assign w_hex[i*8 +: 8] = w_seg;
  end

  // character register and valid flag
  always_ff @(posedge fr_CLK or negedge fr_RST_N) begin
    if (!fr_RST_N) begin
      r_chars <= '0;
      r_valid <= 1'b0;
    end else if (fr_load) begin
      r_chars <= fr_chars;
      r_valid <= 1'b1;
    end
  end

  // scroll state and registered outputs
  always_ff @(posedge fr_CLK or negedge fr_RST_N) begin
    if (!fr_RST_N) begin
      r_presc  <= '0;
      r_offset <= '0;
      r_tick   <= 1'b0;
      r_hex    <= '1;
    end else begin
      r_presc  <= w_presc_nxt;
      r_offset <= w_offset_nxt;
      r_tick   <= w_step;
      r_hex    <= w_hex;
    end
  end

  assign to_HEX    = r_hex;
  assign to_offset = r_offset;
  assign to_tick   = r_tick;

endmodule

// File: tb/tb_char_scroll_display.sv
// Directed bench for char_scroll_display: a 4x2-bit instance and a 3x3-bit instance,
// both with TICK_DIV = 4, sharing clock and reset.
module tb_char_scroll_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  a_chars = 8'h00;
  logic        a_load = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [1:0]  a_sel = 2'b00;
  logic [31:0] a_hex;
  logic [1:0]  a_off;
  logic        a_tick;

  logic [8:0]  b_chars = 9'h000;
  logic        b_load = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [1:0]  b_sel = 2'b00;
  logic [23:0] b_hex;
  logic [1:0]  b_off;
  logic        b_tick;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  char_scroll_display #(.N_DIGITS(4), .CHAR_W(2), .TICK_DIV(4)) u_dut_a (
    .fr_CLK(clk), .fr_RST_N(rst_n), .fr_chars(a_chars), .fr_load(a_load),
    .fr_mode(a_mode), .fr_sel(a_sel), .to_HEX(a_hex), .to_offset(a_off), .to_tick(a_tick)
  );

  char_scroll_display #(.N_DIGITS(3), .CHAR_W(3), .TICK_DIV(4)) u_dut_b (
    .fr_CLK(clk), .fr_RST_N(rst_n), .fr_chars(b_chars), .fr_load(b_load),
    .fr_mode(b_mode), .fr_sel(b_sel), .to_HEX(b_hex), .to_offset(b_off), .to_tick(b_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    a_mode = 2'b01;
    #12;
    n_checks += 4;
    if (a_hex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_hex_a got=%h exp=%h", a_hex, 32'hFFFF_FFFF); end
    if (a_off !== 2'd0) begin n_fail++; $display("FAIL rst_off_a got=%0d exp=0", a_off); end
    if (a_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick_a got=%b exp=0", a_tick); end
    if (b_hex !== 24'hFF_FFFF) begin n_fail++; $display("FAIL rst_hex_b got=%h exp=%h", b_hex, 24'hFF_FFFF); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_blank_scroll();
    for (int k = 1; k <= 20; k++) begin
      logic       exp_tick;
      logic [1:0] exp_off;
      step();
      exp_tick = (k % 4 == 0);
      exp_off  = 2'((k / 4) % 4);
      n_checks += 3;
      if (a_hex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t1_hex k=%0d got=%h exp=%h", k, a_hex, 32'hFFFF_FFFF); end
      if (a_tick !== exp_tick) begin n_fail++; $display("FAIL t1_tick k=%0d got=%b exp=%b", k, a_tick, exp_tick); end
      if (a_off !== exp_off) begin n_fail++; $display("FAIL t1_off k=%0d got=%0d exp=%0d", k, a_off, exp_off); end
    end
  endtask

  task automatic test_manual();
    a_chars = 8'b11_10_01_00;
    a_load  = 1'b1;
    a_mode  = 2'b00;
    a_sel   = 2'd0;
    step();
    a_load = 1'b0;
    n_checks += 2;
    if (a_off !== 2'd0) begin n_fail++; $display("FAIL t2_off0 got=%0d exp=0", a_off); end
    if (a_hex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t2_latency got=%h exp=%h", a_hex, 32'hFFFF_FFFF); end
    step();
    n_checks++;
    if (a_hex !== 32'hC0F9_86A1) begin n_fail++; $display("FAIL t2_sel0 got=%h exp=%h", a_hex, 32'hC0F9_86A1); end
    a_sel = 2'd1;
    step();
    n_checks += 2;
    if (a_off !== 2'd1) begin n_fail++; $display("FAIL t2_off1 got=%0d exp=1", a_off); end
    if (a_hex !== 32'hC0F9_86A1) begin n_fail++; $display("FAIL t2_sel1_early got=%h exp=%h", a_hex, 32'hC0F9_86A1); end
    step();
    n_checks++;
    if (a_hex !== 32'hF986_A1C0) begin n_fail++; $display("FAIL t2_sel1 got=%h exp=%h", a_hex, 32'hF986_A1C0); end
    a_sel = 2'd3;
    step();
    step();
    n_checks += 2;
    if (a_off !== 2'd3) begin n_fail++; $display("FAIL t2_off3 got=%0d exp=3", a_off); end
    if (a_hex !== 32'hA1C0_F986) begin n_fail++; $display("FAIL t2_sel3 got=%h exp=%h", a_hex, 32'hA1C0_F986); end
  endtask

  task automatic test_right_hold();
    a_sel = 2'd0;
    step();
    a_mode = 2'b10;
    for (int k = 1; k <= 22; k++) begin
      logic       exp_tick;
      logic [1:0] exp_off;
      step();
      exp_tick = (k % 4 == 0);
      exp_off  = 2'((4 - (k / 4) % 4) % 4);
      n_checks += 2;
      if (a_tick !== exp_tick) begin n_fail++; $display("FAIL t3_tick k=%0d got=%b exp=%b", k, a_tick, exp_tick); end
      if (a_off !== exp_off) begin n_fail++; $display("FAIL t3_off k=%0d got=%0d exp=%0d", k, a_off, exp_off); end
    end
    a_mode = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks += 2;
      if (a_tick !== 1'b0) begin n_fail++; $display("FAIL t3_hold_tick k=%0d got=%b exp=0", k, a_tick); end
      if (a_off !== 2'd3) begin n_fail++; $display("FAIL t3_hold_off k=%0d got=%0d exp=3", k, a_off); end
    end
    n_checks++;
    if (a_hex !== 32'hA1C0_F986) begin n_fail++; $display("FAIL t3_hold_hex got=%h exp=%h", a_hex, 32'hA1C0_F986); end
  endtask

  task automatic test_load_on_tick();
    a_mode = 2'b01;
    step();
    step();
    step();
    a_chars = 8'b00_01_10_11;
    a_load  = 1'b1;
    step();
    a_load = 1'b0;
    n_checks += 3;
    if (a_tick !== 1'b1) begin n_fail++; $display("FAIL t4_tick got=%b exp=1", a_tick); end
    if (a_off !== 2'd0) begin n_fail++; $display("FAIL t4_off got=%0d exp=0", a_off); end
    if (a_hex !== 32'hA1C0_F986) begin n_fail++; $display("FAIL t4_old_hex got=%h exp=%h", a_hex, 32'hA1C0_F986); end
    step();
    n_checks++;
    if (a_hex !== 32'hA186_F9C0) begin n_fail++; $display("FAIL t4_new_hex got=%h exp=%h", a_hex, 32'hA186_F9C0); end
  endtask

  task automatic test_async_reset();
    step();
    step();
    step();
    n_checks += 2;
    if (a_tick !== 1'b1) begin n_fail++; $display("FAIL t6_pre_tick got=%b exp=1", a_tick); end
    if (a_off !== 2'd1) begin n_fail++; $display("FAIL t6_pre_off got=%0d exp=1", a_off); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (a_hex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t6_async_hex got=%h exp=%h", a_hex, 32'hFFFF_FFFF); end
    if (a_off !== 2'd0) begin n_fail++; $display("FAIL t6_async_off got=%0d exp=0", a_off); end
    if (a_tick !== 1'b0) begin n_fail++; $display("FAIL t6_async_tick got=%b exp=0", a_tick); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic       exp_tick;
      logic [1:0] exp_off;
      step();
      exp_tick = (k == 4);
      exp_off  = (k >= 4) ? 2'd1 : 2'd0;
      n_checks += 2;
      if (a_tick !== exp_tick) begin n_fail++; $display("FAIL t6_tick k=%0d got=%b exp=%b", k, a_tick, exp_tick); end
      if (a_off !== exp_off) begin n_fail++; $display("FAIL t6_off k=%0d got=%0d exp=%0d", k, a_off, exp_off); end
    end
    n_checks++;
    if (a_hex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t6_valid_cleared got=%h exp=%h", a_hex, 32'hFFFF_FFFF); end
  endtask

  task automatic test_three_digits();
    logic [23:0] hex_tab [3];
    hex_tab[0] = 24'hFF86A1;
    hex_tab[1] = 24'h86A1FF;
    hex_tab[2] = 24'hA1FF86;
    b_chars = {3'd4, 3'd1, 3'd0};
    b_load  = 1'b1;
    b_mode  = 2'b01;
    b_sel   = 2'd3;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0]  exp_off;
      logic [23:0] exp_hex;
      step();
      b_load  = 1'b0;
      exp_off = 2'((k / 4) % 3);
      exp_hex = (k == 1) ? 24'hFF_FFFF : hex_tab[((k - 1) / 4) % 3];
      n_checks += 2;
      if (b_off !== exp_off) begin n_fail++; $display("FAIL t5_off k=%0d got=%0d exp=%0d", k, b_off, exp_off); end
      if (b_hex !== exp_hex) begin n_fail++; $display("FAIL t5_hex k=%0d got=%h exp=%h", k, b_hex, exp_hex); end
    end
    b_mode = 2'b00;
    b_sel  = 2'd1;
    step();
    n_checks++;
    if (b_off !== 2'd1) begin n_fail++; $display("FAIL t5_sel1 got=%0d exp=1", b_off); end
    b_sel = 2'd3;
    step();
    step();
    n_checks += 2;
    if (b_off !== 2'd1) begin n_fail++; $display("FAIL t5_sel3_ignored got=%0d exp=1", b_off); end
    if (b_hex !== 24'h86A1FF) begin n_fail++; $display("FAIL t5_sel3_hex got=%h exp=%h", b_hex, 24'h86A1FF); end
    b_sel = 2'd2;
    step();
    step();
    n_checks += 2;
    if (b_off !== 2'd2) begin n_fail++; $display("FAIL t5_sel2 got=%0d exp=2", b_off); end
    if (b_hex !== 24'hA1FF86) begin n_fail++; $display("FAIL t5_sel2_hex got=%h exp=%h", b_hex, 24'hA1FF86); end
  endtask

  initial begin
    test_reset();
    test_blank_scroll();
    test_manual();
    test_right_hold();
    test_load_on_tick();
    test_async_reset();
    test_three_digits();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
